// File: rtl/vending_ctrl_multi_pkg.sv
// Shared types and default widths for the multi-product vending controller.
package vending_ctrl_multi_pkg;

  localparam int unsigned COIN_W_DEF     = 5;
  localparam int unsigned CRED_W_DEF     = 7;
  localparam int unsigned N_PROD_DEF     = 4;
  localparam int unsigned SEL_W_DEF      = 2;
  localparam int unsigned STOCK_W_DEF    = 4;
  localparam int unsigned STOCK_INIT_DEF = 8;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3
  } state_e;

  // Operations on the credit accumulator
  typedef enum logic [1:0] {
    ACC_HOLD = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2,
    ACC_CLR  = 2'd3
  } acc_op_e;

endpackage

// File: rtl/vending_ctrl_multi_credit_acc.sv
// Credit accumulator: add with overflow refusal, subtract, clear.
module vending_ctrl_multi_credit_acc
  import vending_ctrl_multi_pkg::*;
#(
  parameter int unsigned COIN_W = COIN_W_DEF,
  parameter int unsigned CRED_W = CRED_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  acc_op_e           op,
  input  logic [COIN_W-1:0] add_val,
  input  logic [CRED_W-1:0] sub_val,
  output logic [CRED_W-1:0] credit,
  output logic              ovf_c
);

  logic [CRED_W:0] sum_c;

  // One extra bit on the sum exposes overflow of the credit range
  assign sum_c = {1'b0, credit} + (CRED_W+1)'(add_val);
  assign ovf_c = sum_c[CRED_W];

  // Credit register; an overflowing add leaves it untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit <= '0;
    end else begin
      case (op)
        ACC_ADD: if (!sum_c[CRED_W]) credit <= sum_c[CRED_W-1:0];
        ACC_SUB: credit <= credit - sub_val;
        ACC_CLR: credit <= '0;
        default: credit <= credit;
      endcase
    end
  end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller with per-product price and stock.
// Optional feature macro VEND_CHANGE_EN: return leftover credit via the
// change_valid/change_ready handshake after each vend.
module vending_ctrl_multi
  import vending_ctrl_multi_pkg::*;
#(
  parameter int unsigned COIN_W     = COIN_W_DEF,
  parameter int unsigned CRED_W     = CRED_W_DEF,
  parameter int unsigned N_PROD     = N_PROD_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF,
  parameter int unsigned STOCK_W    = STOCK_W_DEF,
  parameter int unsigned STOCK_INIT = STOCK_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coin_valid,
  input  logic [COIN_W-1:0]        coin_value,
  output logic                     coin_ready,
  output logic                     coin_reject,
  input  logic                     buy_req,
  input  logic [SEL_W-1:0]         buy_sel,
  input  logic [N_PROD*CRED_W-1:0] price,
  output logic                     buy_ack,
  output logic                     vend,
  output logic [SEL_W-1:0]         vend_sel,
  output logic                     no_funds,
  output logic                     sold_out,
  output logic [CRED_W-1:0]        credit,
  output logic                     change_valid,
  output logic [CRED_W-1:0]        change_value,
  input  logic                     change_ready
);

  state_e              state_q;
  state_e              state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [CRED_W-1:0]   price_q;
  logic [STOCK_W-1:0]  stock_q [N_PROD];
  logic [CRED_W-1:0]   price_tab [N_PROD];
  acc_op_e             acc_op;
  logic                acc_ovf_c;
  logic                latch;
  logic                stock_dec;
  logic                coin_reject_d;
  logic                buy_ack_d;
  logic                vend_d;
  logic                no_funds_d;
  logic                sold_out_d;

  // Unpack the flat price bus into a table
  for (genvar g = 0; g < int'(N_PROD); g++) begin : g_price
    assign price_tab[g] = price[g*CRED_W +: CRED_W];
  end

  vending_ctrl_multi_credit_acc #(
    .COIN_W (COIN_W),
    .CRED_W (CRED_W)
  ) u_credit_acc (
    .clk     (clk),
    .reset   (reset),
    .op      (acc_op),
    .add_val (coin_value),
    .sub_val (price_q),
    .credit  (credit),
    .ovf_c   (acc_ovf_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle actions
  always_comb begin
    state_d       = state_q;
    acc_op        = ACC_HOLD;
    latch         = 1'b0;
    stock_dec     = 1'b0;
    coin_reject_d = 1'b0;
    buy_ack_d     = 1'b0;
    vend_d        = 1'b0;
    no_funds_d    = 1'b0;
    sold_out_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Coin wins; a request still held during its own ack cycle is not a new one
        if (coin_valid) begin
          if (acc_ovf_c) coin_reject_d = 1'b1;
          else           acc_op        = ACC_ADD;
        end else if (buy_req && !buy_ack) begin
          latch   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        buy_ack_d = 1'b1;
        if (stock_q[sel_q] == '0) begin
          sold_out_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (credit < price_q) begin
          no_funds_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          acc_op    = ACC_SUB;
          stock_dec = 1'b1;
          vend_d    = 1'b1;
          state_d   = ST_VEND;
        end
      end
      ST_VEND: begin
`ifdef VEND_CHANGE_EN
        state_d = (credit != '0) ? ST_CHANGE : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_CHANGE: begin
`ifdef VEND_CHANGE_EN
        if (change_ready) begin
          acc_op  = ACC_CLR;
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Purchase context captured when a request is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= '0;
      price_q <= '0;
    end else if (latch) begin
      sel_q   <= buy_sel;
      price_q <= price_tab[buy_sel];
    end
  end

  // Stock counters; decrement only happens on a vend, so zero is sticky
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_PROD); i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else if (stock_dec) begin
      stock_q[sel_q] <= stock_q[sel_q] - STOCK_W'(1);
    end
  end

  // Registered handshake and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coin_ready  <= 1'b1;
      coin_reject <= 1'b0;
      buy_ack     <= 1'b0;
      vend        <= 1'b0;
      vend_sel    <= '0;
      no_funds    <= 1'b0;
      sold_out    <= 1'b0;
    end else begin
      coin_ready  <= (state_d == ST_IDLE);
      coin_reject <= coin_reject_d;
      buy_ack     <= buy_ack_d;
      vend        <= vend_d;
      no_funds    <= no_funds_d;
      sold_out    <= sold_out_d;
      if (vend_d) vend_sel <= sel_q;
    end
  end

`ifdef VEND_CHANGE_EN
  // Change offer mirrors the CHANGE state; credit is stable while offered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_valid <= 1'b0;
      change_value <= '0;
    end else begin
      change_valid <= (state_d == ST_CHANGE);
      change_value <= (state_d == ST_CHANGE) ? credit : '0;
    end
  end
`else
  logic unused_change_ready;
  assign unused_change_ready = change_ready;
  assign change_valid        = 1'b0;
  assign change_value        = '0;
`endif

endmodule
